ysyx_041461_if_refill_ctrl: RTL and testbench
=============================================

Name: ysyx_041461_if_refill_ctrl

Overview:
- Fetch-stage miss/refill sequencer. It sits between the IF2 pipeline register outputs and the AXI read channel.
- It inspects the registered 8-way hit vector. On a miss it stalls IF1/IF2, fetches one cache line over an AXI INCR burst and streams the beats into the selected victim way.
- It releases the pipeline one cycle after the refill so IF2 re-looks-up and hits.
- It handles redirects (flush) arriving mid-refill without violating AXI.

Parameters:
- LINE_BEATS, 2: 64-bit beats per cache line (power of 2, 2..8).
- WAYS, 8: number of ways; the victim index is log2(WAYS) bits wide.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ctrl_valid_in  in  1  IF2 register valid.
- ctrl_pc_in  in  64  IF2 register pc.
- ctrl_hit_in  in  WAYS  {hit8..hit1} from IF2 register.
- ctrl_fault_in  in  1  IF2 entry already carries a trap; never refill.
- ctrl_flush_in  in  1  redirect from later stage; single-cycle pulse.
- ctrl_ds_ready_in  in  1  ID stage can accept.
- IF1reg_enable  out  1  IF1 register enable.
- IF2reg_enable  out  1  IF2 register enable.
- ctrl_flush_out  out  1  flush applied to IF regs (load bubble).
- arvalid  out  1.
- araddr  out  64.
- arlen  out  8.
- arsize  out  3.
- arburst  out  2.
- arready  in  1.
- rvalid  in  1.
- rdata  in  64.
- rresp  in  2.
- rlast  in  1.
- rready  out  1.
- refill_we  out  1  cache data write strobe.
- refill_way  out  log2(WAYS)  victim way.
- refill_beat  out  log2(LINE_BEATS)  beat index in line.
- refill_addr  out  64  line-aligned address.
- refill_data  out  64  = rdata.
- refill_done  out  1  one-cycle pulse; cache sets tag/valid for refill_way.
- ctrl_bus_err  out  1  one-cycle pulse on burst with any rresp != 0.

Behaviour:
- Reset: state IDLE. Victim counter = 0, beat counter = 0, discard = 0, err = 0, flush_pending = 0. All outputs 0 except arsize = 3 and arburst = 2'b01 (constant).
- States: IDLE, AR, R, DONE.
- miss = ctrl_valid_in & (ctrl_hit_in == 0) & ~ctrl_fault_in.
- IDLE:
  - ctrl_flush_in has priority: enables = 1, ctrl_flush_out = 1, no refill start, even if miss is true.
  - Else if miss: enables = 0, latch line address (ctrl_pc_in with low log2(LINE_BEATS*8) bits cleared), go to AR next cycle.
  - Else: enables = ctrl_ds_ready_in.
  - More than one hit bit set counts as a hit; no refill.
- AR:
  - arvalid = 1; araddr = latched line address; arlen = LINE_BEATS-1.
  - Hold all values stable until arready, then go to R with beat counter cleared.
  - Enables = 0.
- R:
  - rready = 1.
  - Each rvalid beat: refill_we = rvalid & ~discard & (rresp == 0); refill_beat = beat counter; beat counter increments.
  - Any rresp != 0 sets err and suppresses refill_we for the rest of the burst.
  - Burst ends on rvalid & rlast. The beat counter reaching LINE_BEATS-1 without rlast is a protocol violation and is handled as rlast.
  - At end of burst:
    - discard or err: go to IDLE. ctrl_bus_err pulses if err and not discard. The victim counter does not advance.
    - Otherwise: go to DONE.
- DONE (one cycle): refill_done = 1, refill_way = victim counter, enables = 0. The victim counter increments modulo WAYS. Go to IDLE.
- Flush while in AR, R or DONE: set discard and flush_pending. Enables stay 0; the AXI transaction completes normally with refill writes suppressed.
  - From DONE the line is still committed, because all beats are already written.
  - On the first IDLE cycle with flush_pending: ctrl_flush_out = 1, enables = 1, then clear flush_pending and discard. No miss is evaluated that cycle.
- Latency: a miss detected in cycle t gives arvalid in t+1. With zero-wait arready and rvalid, first data arrives at t+2, refill_done at t+2+LINE_BEATS, and enables return high at t+3+LINE_BEATS.
- Reset mid-burst forces IDLE immediately. The interconnect is reset by the same rst.

Test Plan:
- Hit path: valid = 1, hit = 8'h04, ds_ready = 1 -> IF1/IF2 enable = 1, arvalid never asserts. With ds_ready = 0 -> enables = 0.
- Clean miss: pc = 0x3000_0018, hit = 0, arready/rvalid immediate -> araddr = 0x3000_0010, arlen = 1, two refill_we with beat 0/1, way 0. refill_done at miss+4, enables high at miss+5; next miss uses way 1.
- Backpressure: arready delayed 3 cycles, rvalid gaps -> araddr/arvalid stable throughout, refill_we only on rvalid beats, enables remain 0.
- Flush during R after beat 0 -> beat 1 not written, no refill_done, victim counter unchanged. ctrl_flush_out = 1 with enables = 1 on the first IDLE cycle.
- Error response: rresp = 2'b10 on beat 0 -> no refill_we, no refill_done, ctrl_bus_err pulses once at burst end.
- Miss coincident with flush in IDLE, and fault with hit = 0 -> no AR issued; flush_out only for the flush case.

Source files
------------

// File: rtl/ysyx_041461_if_refill_ctrl_if.sv
// AXI read-address and read-data channel bundle between the fetch refill sequencer
// and the memory interconnect (64-bit data, INCR bursts).
interface ysyx_041461_if_refill_ctrl_if;
  logic        arvalid;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arready;
  logic        rvalid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rready;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/ysyx_041461_if_refill_ctrl.sv
// Fetch-stage miss/refill sequencer: stalls IF1/IF2 on an I-cache miss, fetches one
// line over an AXI INCR burst into the victim way, and absorbs redirects mid-refill.
module ysyx_041461_if_refill_ctrl #(
  parameter int LINE_BEATS = 2,
  parameter int WAYS       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ctrl_valid_in,
  input  logic [63:0]                   ctrl_pc_in,
  input  logic [WAYS-1:0]               ctrl_hit_in,
  input  logic                          ctrl_fault_in,
  input  logic                          ctrl_flush_in,
  input  logic                          ctrl_ds_ready_in,
  output logic                          IF1reg_enable,
  output logic                          IF2reg_enable,
  output logic                          ctrl_flush_out,
  ysyx_041461_if_refill_ctrl_if.master  axi,
  output logic                          refill_we,
  output logic [$clog2(WAYS)-1:0]       refill_way,
  output logic [$clog2(LINE_BEATS)-1:0] refill_beat,
  output logic [63:0]                   refill_addr,
  output logic [63:0]                   refill_data,
  output logic                          refill_done,
  output logic                          ctrl_bus_err
);

  localparam int BEAT_W = $clog2(LINE_BEATS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int OFF_W  = $clog2(LINE_BEATS * 8);

  localparam logic [63:0]       LINE_MASK = ~((64'd1 << OFF_W) - 64'd1);
  localparam logic [7:0]        ARLEN     = 8'(LINE_BEATS - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
  localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(WAYS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [63:0]        line_addr_q, line_addr_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [WAY_W-1:0]   victim_q, victim_d;
  logic               discard_q, discard_d;
  logic               err_q, err_d;
  logic               flush_pending_q, flush_pending_d;

  logic miss;
  logic enable;
  logic err_now;
  logic burst_end;

  assign miss = ctrl_valid_in & (ctrl_hit_in == '0) & ~ctrl_fault_in;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can leave it
    // unassigned, which would otherwise infer a latch.
    state_d         = state_q;
    line_addr_d     = line_addr_q;
    beat_d          = beat_q;
    victim_d        = victim_q;
    discard_d       = discard_q;
    err_d           = err_q;
    flush_pending_d = flush_pending_q;
    enable          = 1'b0;
    ctrl_flush_out  = 1'b0;
    axi.arvalid     = 1'b0;
    axi.araddr      = '0;
    axi.arlen       = '0;
    axi.rready      = 1'b0;
    refill_we       = 1'b0;
    refill_done     = 1'b0;
    ctrl_bus_err    = 1'b0;
    err_now         = err_q;
    burst_end       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A redirect that landed during a refill is replayed here before any new lookup.
        if (flush_pending_q) begin
          enable          = 1'b1;
          ctrl_flush_out  = 1'b1;
          flush_pending_d = 1'b0;
          discard_d       = 1'b0;
        end else if (ctrl_flush_in) begin
          enable         = 1'b1;
          ctrl_flush_out = 1'b1;
        end else if (miss) begin
          line_addr_d = ctrl_pc_in & LINE_MASK;
          state_d     = S_AR;
        end else begin
          enable = ctrl_ds_ready_in;
        end
      end

      S_AR: begin
        axi.arvalid = 1'b1;
        axi.araddr  = line_addr_q;
        axi.arlen   = ARLEN;
        if (axi.arready) begin
          state_d = S_R;
          beat_d  = '0;
        end
      end

      S_R: begin
        axi.rready = 1'b1;
        if (axi.rvalid) begin
          err_now   = err_q | (axi.rresp != 2'b00);
          refill_we = ~discard_q & ~err_now;
          beat_d    = beat_q + BEAT_W'(1);
          err_d     = err_now;
          // An overlong burst is cut at the line size so the beat index never wraps.
          burst_end = axi.rlast | (beat_q == LAST_BEAT);
          if (burst_end) begin
            err_d = 1'b0;
            if (discard_q | err_now) begin
              state_d      = S_IDLE;
              ctrl_bus_err = err_now & ~discard_q;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end

      S_DONE: begin
        refill_done = 1'b1;
        victim_d    = (victim_q == LAST_WAY) ? '0 : victim_q + WAY_W'(1);
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if ((state_q != S_IDLE) && ctrl_flush_in) begin
      discard_d       = 1'b1;
      flush_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of its inputs regardless of statement order.
    if (rst) begin
      state_q         <= S_IDLE;
      line_addr_q     <= '0;
      beat_q          <= '0;
      victim_q        <= '0;
      discard_q       <= 1'b0;
      err_q           <= 1'b0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      line_addr_q     <= line_addr_d;
      beat_q          <= beat_d;
      victim_q        <= victim_d;
      discard_q       <= discard_d;
      err_q           <= err_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  assign IF1reg_enable = enable;
  assign IF2reg_enable = enable;
  assign axi.arsize    = 3'd3;
  assign axi.arburst   = 2'b01;
  assign refill_way    = victim_q;
  assign refill_beat   = beat_q;
  assign refill_addr   = line_addr_q;
  assign refill_data   = axi.rdata;

endmodule

// File: tb/tb_ysyx_041461_if_refill_ctrl.sv
// Self-checking bench for the fetch refill sequencer: a transaction-level model of the
// expected line address, victim way, written beats and pipeline release.
module tb_ysyx_041461_if_refill_ctrl;
  localparam int LB   = 2;
  localparam int WAYS = 8;
  localparam int BW   = $clog2(LB);
  localparam int WW   = $clog2(WAYS);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          valid, fault, flush, ds_ready;
  logic [63:0]   pc;
  logic [WAYS-1:0] hit;
  logic          if1_en, if2_en, flush_out;
  logic          refill_we, refill_done, bus_err;
  logic [WW-1:0] refill_way;
  logic [BW-1:0] refill_beat;
  logic [63:0]   refill_addr, refill_data;

  ysyx_041461_if_refill_ctrl_if axi ();

  ysyx_041461_if_refill_ctrl #(.LINE_BEATS(LB), .WAYS(WAYS)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .ctrl_valid_in    (valid),
    .ctrl_pc_in       (pc),
    .ctrl_hit_in      (hit),
    .ctrl_fault_in    (fault),
    .ctrl_flush_in    (flush),
    .ctrl_ds_ready_in (ds_ready),
    .IF1reg_enable    (if1_en),
    .IF2reg_enable    (if2_en),
    .ctrl_flush_out   (flush_out),
    .axi              (axi),
    .refill_we        (refill_we),
    .refill_way       (refill_way),
    .refill_beat      (refill_beat),
    .refill_addr      (refill_addr),
    .refill_data      (refill_data),
    .refill_done      (refill_done),
    .ctrl_bus_err     (bus_err)
  );

  int tests = 0;
  int fails = 0;
  int exp_victim = 0;

  task automatic idle_inputs();
    valid = 1'b0; pc = '0; hit = '0; fault = 1'b0; flush = 1'b0; ds_ready = 1'b1;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    ds_ready = 1'b0;
    @(negedge clk); #1;
    tests++;
    if ({if1_en, if2_en, flush_out, axi.arvalid, axi.rready, refill_we, refill_done, bus_err} !== 8'h00) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {if1_en, if2_en, flush_out, axi.arvalid, axi.rready, refill_we, refill_done, bus_err});
    end
    tests++;
    if (axi.arsize !== 3'd3 || axi.arburst !== 2'b01) begin
      fails++;
      $display("FAIL reset_const: arsize %0d arburst %b expected 3 01", axi.arsize, axi.arburst);
    end
    tests++;
    if (axi.araddr !== 64'd0 || axi.arlen !== 8'd0 || refill_way !== '0 || refill_beat !== '0 || refill_addr !== 64'd0) begin
      fails++;
      $display("FAIL reset_regs: araddr %h arlen %0d way %0d beat %0d addr %h expected zeros",
               axi.araddr, axi.arlen, refill_way, refill_beat, refill_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_victim = 0;
  endtask

  task automatic test_hit();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      valid    = 1'b1;
      pc       = {$urandom, $urandom};
      hit      = (i == 1) ? 8'h81 : (i < 3) ? 8'h04 : WAYS'($urandom_range(1, (1 << WAYS) - 1));
      ds_ready = (i == 2) ? 1'b0 : (i < 2) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      tests++;
      if (if1_en !== ds_ready || if2_en !== ds_ready || axi.arvalid !== 1'b0 || flush_out !== 1'b0) begin
        fails++;
        $display("FAIL hit_%0d: en %b%b arvalid %b flush_out %b expected en %b%b arvalid 0 flush_out 0",
                 i, if1_en, if2_en, axi.arvalid, flush_out, ds_ready, ds_ready);
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    tests++;
    if (axi.arvalid !== 1'b0) begin
      fails++;
      $display("FAIL hit_no_ar: arvalid %b expected 0", axi.arvalid);
    end
  endtask

  // One complete miss: the bench plays the AXI slave and the model predicts every
  // write strobe, the victim way, pulses and the cycle the pipeline is released.
  task automatic run_miss(input string name, input logic [63:0] miss_pc, input int ar_wait,
                          input bit gaps, input int err_beat, input int flush_after,
                          input bit check_latency);
    logic [63:0] exp_addr;
    int  beats_sent, writes, exp_writes, dones, errs, done_cyc, end_cyc, ar_cnt, gap_run, idle_cyc;
    bit  flushed, ended, finished, exp_done, exp_err, exp_we, wr_ok;
    exp_addr   = miss_pc & ~64'(LB * 8 - 1);
    exp_done   = (err_beat < 0) && (flush_after < 0);
    exp_err    = (err_beat >= 0) && (flush_after < 0);
    exp_writes = 0;
    for (int k = 0; k < LB; k++)
      if ((err_beat < 0 || k < err_beat) && (flush_after < 0 || k <= flush_after)) exp_writes++;
    beats_sent = 0; writes = 0; dones = 0; errs = 0; done_cyc = -1; end_cyc = -1;
    ar_cnt = 0; gap_run = 0; idle_cyc = -1; flushed = 0; ended = 0; finished = 0;

    @(negedge clk);
    idle_inputs();
    valid = 1'b1; hit = '0; pc = miss_pc;
    #1;
    tests++;
    if (if1_en !== 1'b0 || if2_en !== 1'b0 || axi.arvalid !== 1'b0) begin
      fails++;
      $display("FAIL %s_miss_cycle: en %b%b arvalid %b expected 00 0", name, if1_en, if2_en, axi.arvalid);
    end

    for (int cyc = 1; cyc < 100 && !finished; cyc++) begin
      @(negedge clk);
      valid = 1'b0; flush = 1'b0;
      axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
      axi.arready = axi.arvalid && (ar_cnt >= ar_wait);
      if (axi.arvalid) ar_cnt++;
      if (axi.rready && !ended) begin
        if (flush_after >= 0 && !flushed && beats_sent == flush_after + 1) begin
          flush = 1'b1;
          flushed = 1;
        end else if (!gaps || gap_run >= 2 || $urandom_range(0, 1) == 1) begin
          axi.rvalid = 1'b1;
          axi.rdata  = {$urandom, $urandom};
          axi.rresp  = (beats_sent == err_beat) ? 2'b10 : 2'b00;
          axi.rlast  = (beats_sent == LB - 1);
          gap_run    = 0;
        end else begin
          gap_run++;
        end
      end
      #1;
      if (ended && cyc == end_cyc + (exp_done ? 2 : 1)) begin
        idle_cyc = cyc;
        finished = 1;
        tests++;
        if (if1_en !== 1'b1 || if2_en !== 1'b1 || flush_out !== (flush_after >= 0)) begin
          fails++;
          $display("FAIL %s_release: en %b%b flush_out %b expected 11 %b",
                   name, if1_en, if2_en, flush_out, flush_after >= 0);
        end
      end else begin
        tests++;
        if (if1_en !== 1'b0 || if2_en !== 1'b0 || flush_out !== 1'b0) begin
          fails++;
          $display("FAIL %s_stall_c%0d: en %b%b flush_out %b expected 00 0", name, cyc, if1_en, if2_en, flush_out);
        end
        if (axi.arvalid) begin
          tests++;
          if (axi.araddr !== exp_addr || axi.arlen !== 8'(LB - 1) || axi.arsize !== 3'd3 || axi.arburst !== 2'b01) begin
            fails++;
            $display("FAIL %s_ar: araddr %h arlen %0d expected %h %0d", name, axi.araddr, axi.arlen, exp_addr, LB - 1);
          end
        end
        wr_ok  = (err_beat < 0 || beats_sent < err_beat) && (flush_after < 0 || beats_sent <= flush_after);
        exp_we = axi.rvalid && wr_ok;
        tests++;
        if (refill_we !== exp_we) begin
          fails++;
          $display("FAIL %s_we_c%0d: refill_we %b expected %b", name, cyc, refill_we, exp_we);
        end
        if (refill_we === 1'b1) writes++;
        if (exp_we) begin
          tests++;
          if (refill_beat !== BW'(beats_sent) || refill_data !== axi.rdata || refill_addr !== exp_addr) begin
            fails++;
            $display("FAIL %s_beat: beat %0d data %h addr %h expected %0d %h %h",
                     name, refill_beat, refill_data, refill_addr, beats_sent, axi.rdata, exp_addr);
          end
        end
        if (refill_done === 1'b1) begin
          dones++;
          done_cyc = cyc;
          tests++;
          if (refill_way !== WW'(exp_victim) || refill_addr !== exp_addr) begin
            fails++;
            $display("FAIL %s_done_way: way %0d addr %h expected %0d %h", name, refill_way, refill_addr, exp_victim, exp_addr);
          end
        end
        if (bus_err === 1'b1) errs++;
        if (axi.rvalid) begin
          beats_sent++;
          if (axi.rlast) begin
            ended   = 1;
            end_cyc = cyc;
          end
        end
      end
    end

    tests++;
    if (!finished) begin
      fails++;
      $display("FAIL %s_timeout: burst ended %b expected release within 100 cycles", name, ended);
    end
    tests++;
    if (writes != exp_writes || dones != int'(exp_done) || errs != int'(exp_err)) begin
      fails++;
      $display("FAIL %s_counts: writes %0d done %0d bus_err %0d expected %0d %0d %0d",
               name, writes, dones, errs, exp_writes, exp_done, exp_err);
    end
    if (check_latency) begin
      tests++;
      if (done_cyc != 2 + LB || idle_cyc != 3 + LB) begin
        fails++;
        $display("FAIL %s_latency: done at +%0d release at +%0d expected +%0d +%0d",
                 name, done_cyc, idle_cyc, 2 + LB, 3 + LB);
      end
    end
    if (exp_done) exp_victim = (exp_victim + 1) % WAYS;
    idle_inputs();
  endtask

  task automatic test_clean_miss();
    run_miss("clean0", 64'h3000_0018, 0, 0, -1, -1, 1);
    run_miss("clean1", 64'h3000_0040, 0, 0, -1, -1, 1);
  endtask

  task automatic test_backpressure();
    run_miss("backpressure", 64'h8000_1234, 3, 1, -1, -1, 0);
  endtask

  task automatic test_flush_in_r();
    run_miss("flush_r", 64'h8000_2008, 0, 0, -1, 0, 0);
  endtask

  task automatic test_bus_error();
    run_miss("bus_err", 64'h8000_3000, 0, 0, 0, -1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      int eb, fa;
      eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LB - 1)) : -1;
      fa = (eb < 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, LB - 2)) : -1;
      run_miss("random", {$urandom, $urandom} & ~64'h3, int'($urandom_range(0, 3)), 1, eb, fa, 0);
    end
  endtask

  task automatic test_idle_flush_and_fault();
    @(negedge clk);
    idle_inputs();
    valid = 1'b1; hit = '0; pc = 64'h4000_0000; flush = 1'b1;
    #1;
    tests++;
    if (flush_out !== 1'b1 || if1_en !== 1'b1 || if2_en !== 1'b1) begin
      fails++;
      $display("FAIL idle_flush: flush_out %b en %b%b expected 1 11", flush_out, if1_en, if2_en);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    tests++;
    if (axi.arvalid !== 1'b0 || flush_out !== 1'b0) begin
      fails++;
      $display("FAIL idle_flush_no_ar: arvalid %b flush_out %b expected 0 0", axi.arvalid, flush_out);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      valid = 1'b1; hit = '0; fault = 1'b1; pc = 64'h4000_0100; ds_ready = 1'(i);
      #1;
      tests++;
      if (flush_out !== 1'b0 || if1_en !== ds_ready || if2_en !== ds_ready || axi.arvalid !== 1'b0) begin
        fails++;
        $display("FAIL fault_%0d: flush_out %b en %b%b arvalid %b expected 0 %b%b 0",
                 i, flush_out, if1_en, if2_en, axi.arvalid, ds_ready, ds_ready);
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    tests++;
    if (axi.arvalid !== 1'b0) begin
      fails++;
      $display("FAIL fault_no_ar: arvalid %b expected 0", axi.arvalid);
    end
  endtask

  task automatic test_mid_reset();
    bit seen_r;
    seen_r = 0;
    if (exp_victim == 0) run_miss("pre_reset", 64'h5000_0000, 0, 0, -1, -1, 0);
    @(negedge clk);
    idle_inputs();
    valid = 1'b1; hit = '0; pc = 64'h6000_0020;
    for (int i = 0; i < 10 && !seen_r; i++) begin
      @(negedge clk);
      valid = 1'b0;
      axi.arready = axi.arvalid;
      if (axi.rready) begin
        seen_r = 1;
        axi.rvalid = 1'b1; axi.rdata = 64'hdead_beef; axi.rresp = 2'b00; axi.rlast = 1'b0;
        rst = 1'b1;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    exp_victim = 0;
    #1;
    tests++;
    if (!seen_r || axi.rready !== 1'b0 || axi.arvalid !== 1'b0 || if1_en !== 1'b1 || refill_done !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: reached_r %b rready %b arvalid %b en %b done %b expected 1 0 0 1 0",
               seen_r, axi.rready, axi.arvalid, if1_en, refill_done);
    end
    run_miss("post_reset", 64'h6000_0028, 0, 0, -1, -1, 1);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_hit();
    test_clean_miss();
    test_backpressure();
    test_flush_in_r();
    test_bus_error();
    test_random();
    test_idle_flush_and_fault();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end
endmodule
